// File: rtl/inert_sensor_resp_if.sv
// -----------------------------------------------------------------------------
// inert_sensor_resp_if
//   SPI link between the inertial-interface master and the emulated sensor.
//   Ports (signals):
//     SS_n  slave select, active low (master -> sensor)
//     SCLK  SPI clock, idles high      (master -> sensor)
//     MOSI  data from master           (master -> sensor)
//     MISO  data to master             (sensor -> master)
//   Modports: master (drives SS_n/SCLK/MOSI), slave (drives MISO).
// -----------------------------------------------------------------------------
interface inert_sensor_resp_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_sensor_resp.sv
// -----------------------------------------------------------------------------
// inert_sensor_resp
//   SPI responder emulating the inertial sensor. Decodes 16-bit frames
//   (R/W, 7-bit address, 8-bit data), holds the init-time config registers,
//   returns pitch-rate / AZ snapshot bytes on reads and raises INT when a new
//   sample has been captured.
//   Ports:
//     clk, rst_n     system clock, asynchronous active-low reset
//     spi            SPI slave side (SS_n, SCLK, MOSI in; MISO out)
//     INT            new sample ready; cleared by a read of 0x22
//     ptch_rt_smpl   pitch-rate value captured at each sample tick
//     AZ_smpl        Z-accel value captured at each sample tick
//     cfg_done       INT1_CTRL == 8'h02 and CTRL2_G != 0
//     ovr            sticky: a sample was replaced while INT was still set
// -----------------------------------------------------------------------------
module inert_sensor_resp #(
   parameter logic [15:0] SMPL_CYCLES = 16'd8192,
   parameter logic [7:0]  WHO_AM_I    = 8'h6A
) (
   input  logic                clk,
   input  logic                rst_n,
   inert_sensor_resp_if.slave  spi,
   output logic                INT,
   input  logic [15:0]         ptch_rt_smpl,
   input  logic [15:0]         AZ_smpl,
   output logic                cfg_done,
   output logic                ovr
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

   // ---------------------------------------------------------------------------
   // Synchronisers: [0],[1] form the double flop, [2] holds the previous
   // synced value for edge detection.
   // ---------------------------------------------------------------------------
   logic [2:0] ss_sync_q;
   logic [2:0] sclk_sync_q;
   logic [1:0] mosi_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: SS_n/SCLK sync chains reset to their idle-high level so that
         // releasing reset never fabricates an edge.
         ss_sync_q   <= '1;
         sclk_sync_q <= '1;
         mosi_sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge value, which is what makes this a shift chain.
         ss_sync_q   <= {ss_sync_q[1:0],   spi.SS_n};
         sclk_sync_q <= {sclk_sync_q[1:0], spi.SCLK};
         mosi_sync_q <= {mosi_sync_q[0],   spi.MOSI};
      end
   end

   logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
   assign ss_fall   =  ss_sync_q[2]   & ~ss_sync_q[1];
   assign ss_rise   = ~ss_sync_q[2]   &  ss_sync_q[1];
   assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
   assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
   assign mosi_s    =  mosi_sync_q[1];

   // ---------------------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [4:0]  cnt_q;        // SCLK rises seen in this frame (0..16)
   logic [7:0]  shift_q;      // last 8 MOSI bits
   logic [7:0]  tx_q;         // response byte being shifted out
   logic        miso_q;
   logic        rw_q;
   logic [6:0]  addr_q;

   logic [7:0]  int1_ctrl_q, ctrl1_xl_q, ctrl2_g_q, ctrl6_q;
   logic [15:0] ptch_snap_q, az_snap_q;
   logic [15:0] ptch_pend_q, az_pend_q;
   logic        pend_vld_q;
   logic [15:0] timer_q;
   logic        int_q, ovr_q;

   // Command byte as it stands on the 8th rise: 7 shifted bits plus the one
   // arriving now.
   logic [7:0] cmd_byte;
   assign cmd_byte = {shift_q[6:0], mosi_s};

   // FSM process 1: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM process 2: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ss_fall) state_d = CMD;
         CMD:     if (ss_rise) state_d = IDLE;
                  else if (sclk_rise && cnt_q == 5'd7) state_d = DATA;
         DATA:    if (ss_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM process 3: control strobes
   logic frm_clr, shift_en, cmd_ld, tx_shift, wr_commit;
   always_comb begin
      // NOTE: every strobe gets a default before the case so that no path
      // leaves it unassigned and no latch is inferred.
      frm_clr   = 1'b0;
      shift_en  = 1'b0;
      cmd_ld    = 1'b0;
      tx_shift  = 1'b0;
      wr_commit = 1'b0;
      unique case (state_q)
         IDLE: frm_clr = ss_fall;
         CMD: begin
            shift_en = sclk_rise && !ss_rise;
            cmd_ld   = sclk_rise && !ss_rise && (cnt_q == 5'd7);
         end
         DATA: begin
            shift_en  = sclk_rise && !ss_rise && (cnt_q < 5'd16);
            tx_shift  = sclk_fall && !ss_rise;
            // Only a complete 16-rise write frame commits; aborts drop it.
            wr_commit = ss_rise && (cnt_q == 5'd16) && !rw_q;
         end
         default: ;
      endcase
   end

   // Read response selected from the command byte being decoded.
   logic [7:0] resp;
   always_comb begin
      resp = 8'h00;
      if (cmd_byte[7]) begin
         unique case (cmd_byte[6:0])
            7'h0D:   resp = int1_ctrl_q;
            7'h0F:   resp = WHO_AM_I;
            7'h10:   resp = ctrl1_xl_q;
            7'h11:   resp = ctrl2_g_q;
            7'h14:   resp = ctrl6_q;
            7'h22:   resp = ptch_snap_q[7:0];
            7'h23:   resp = ptch_snap_q[15:8];
            7'h2C:   resp = az_snap_q[7:0];
            7'h2D:   resp = az_snap_q[15:8];
            default: resp = 8'h00;
         endcase
      end
   end

   // Frame datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
         tx_q    <= '0;
         miso_q  <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         if (frm_clr) begin
            cnt_q  <= '0;
            miso_q <= 1'b0;
         end
         if (shift_en) begin
            shift_q <= {shift_q[6:0], mosi_s};
            cnt_q   <= cnt_q + 5'd1;
         end
         if (cmd_ld) begin
            rw_q   <= cmd_byte[7];
            addr_q <= cmd_byte[6:0];
            tx_q   <= resp;
         end
         // Response bits go out on the falls ahead of rises 9..16.
         if (tx_shift) begin
            miso_q <= (cnt_q < 5'd16) ? tx_q[7] : 1'b0;
            tx_q   <= {tx_q[6:0], 1'b0};
         end
         if (ss_rise) miso_q <= 1'b0;
      end
   end

   // Raw SS_n gates the pin so MISO is low the moment the master deselects.
   assign spi.MISO = miso_q & ~spi.SS_n;

   // ---------------------------------------------------------------------------
   // Config registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int1_ctrl_q <= '0;
         ctrl1_xl_q  <= '0;
         ctrl2_g_q   <= '0;
         ctrl6_q     <= '0;
      end else if (wr_commit) begin
         unique case (addr_q)
            7'h0D:   int1_ctrl_q <= shift_q;
            7'h10:   ctrl1_xl_q  <= shift_q;
            7'h11:   ctrl2_g_q   <= shift_q;
            7'h14:   ctrl6_q     <= shift_q;
            default: ;
         endcase
      end
   end

   assign cfg_done = (int1_ctrl_q == 8'h02) && (ctrl2_g_q != 8'h00);

   // ---------------------------------------------------------------------------
   // Sample timer, snapshots, INT and overrun
   // ---------------------------------------------------------------------------
   logic tick, rd_clr, in_frame;
   assign tick     = cfg_done && (timer_q == SMPL_CYCLES - 16'd1);
   assign rd_clr   = cmd_ld && (cmd_byte == 8'hA2);
   assign in_frame = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q     <= '0;
         int_q       <= 1'b0;
         ovr_q       <= 1'b0;
         ptch_snap_q <= '0;
         az_snap_q   <= '0;
         ptch_pend_q <= '0;
         az_pend_q   <= '0;
         pend_vld_q  <= 1'b0;
      end else begin
         if (!cfg_done || tick) timer_q <= '0;
         else                   timer_q <= timer_q + 16'd1;

         // A tick coinciding with the 0x22 clear wins: the old sample was
         // consumed in that same cycle, so it is not an overrun.
         if (tick) begin
            int_q <= 1'b1;
            if (int_q && !rd_clr) ovr_q <= 1'b1;
         end else if (rd_clr) begin
            int_q <= 1'b0;
         end

         // Snapshots stay frozen while a frame is open; a mid-frame sample is
         // parked and committed once the frame closes.
         if (tick) begin
            if (in_frame) begin
               ptch_pend_q <= ptch_rt_smpl;
               az_pend_q   <= AZ_smpl;
               pend_vld_q  <= 1'b1;
            end else begin
               ptch_snap_q <= ptch_rt_smpl;
               az_snap_q   <= AZ_smpl;
               pend_vld_q  <= 1'b0;
            end
         end else if (pend_vld_q && !in_frame) begin
            ptch_snap_q <= ptch_pend_q;
            az_snap_q   <= az_pend_q;
            pend_vld_q  <= 1'b0;
         end
      end
   end

   assign INT = int_q;
   assign ovr = ovr_q;

endmodule

// File: tb/tb_inert_sensor_resp.sv
`timescale 1ns/1ps
module tb_inert_sensor_resp;

   localparam int N = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        INT, cfg_done, ovr;
   logic [15:0] ptch_rt_smpl, AZ_smpl;

   int cyc     = 0;
   int cfg_cyc = -1;
   int n_chk   = 0;
   int n_pass  = 0;

   inert_sensor_resp_if spi();

   inert_sensor_resp #(
      .SMPL_CYCLES (16'(N)),
      .WHO_AM_I    (8'h6A)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi          (spi),
      .INT          (INT),
      .ptch_rt_smpl (ptch_rt_smpl),
      .AZ_smpl      (AZ_smpl),
      .cfg_done     (cfg_done),
      .ovr          (ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (cfg_done === 1'b1 && cfg_cyc < 0) cfg_cyc = cyc;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One SPI frame, mode 3: MOSI set with each fall, MISO sampled before each
   // rise 9..16. align>0 holds the 8th rise until cycle 'align'.
   task automatic spi_frame(input logic [15:0] tx, input int nbits, input int align,
                            output logic [7:0] rx);
      rx = '0;
      spi.SS_n = 1'b0;
      step(4);
      for (int i = 0; i < nbits; i++) begin
         spi.MOSI = tx[15-i];
         spi.SCLK = 1'b0;
         step(5);
         if (i == 7 && align > 0) begin
            if (cyc > align) check("align_late", cyc, align);
            while (cyc < align) step(1);
         end
         if (i >= 8) rx = {rx[6:0], spi.MISO};
         spi.SCLK = 1'b1;
         step(5);
      end
      spi.SS_n = 1'b1;
      step(6);
   endtask

   task automatic wait_int(input string tag, output int seen);
      int lim;
      lim = cyc + 2 * N;
      while (INT !== 1'b1 && cyc < lim) step(1);
      seen = cyc;
      if (INT !== 1'b1) check(tag, INT, 1'b1);
   endtask

   initial begin
      logic [7:0]  rx;
      logic [15:0] part;
      int          x1, x2, lat;

      spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
      ptch_rt_smpl = 16'h1234;
      AZ_smpl      = 16'hFEDC;
      step(3);
      rst_n = 1'b1;
      step(3);

      // 1: reset in the middle of a frame
      part = 16'hA200;
      spi.SS_n = 1'b0;
      step(4);
      for (int i = 0; i < 6; i++) begin
         spi.MOSI = part[15-i];
         spi.SCLK = 1'b0; step(5);
         spi.SCLK = 1'b1; step(5);
      end
      rst_n = 1'b0;
      #1;
      check("t1_rst_miso", spi.MISO, 1'b0);
      check("t1_rst_int",  INT,      1'b0);
      check("t1_rst_cfg",  cfg_done, 1'b0);
      check("t1_rst_ovr",  ovr,      1'b0);
      step(2);
      spi.SS_n = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(3);
      spi_frame(16'h8F00, 16, 0, rx);
      check("t1_whoami_after_rst", rx, 8'h6A);

      // 5: aborted write does not commit
      spi_frame(16'h10AA, 12, 0, rx);
      spi_frame(16'h9000, 16, 0, rx);
      check("t5_abort_no_write", rx, 8'h00);

      // 4: register reads
      spi_frame(16'h1053, 16, 0, rx);
      spi_frame(16'h9000, 16, 0, rx);
      check("t4_ctrl1_xl", rx, 8'h53);
      spi_frame(16'hFF00, 16, 0, rx);
      check("t4_unmapped", rx, 8'h00);

      // 2: configuration and first sample latency
      spi_frame(16'h0D02, 16, 0, rx);
      check("t2_cfg_partial", cfg_done, 1'b0);
      spi_frame(16'h1150, 16, 0, rx);
      check("t2_cfg_done", cfg_done, 1'b1);
      spi_frame(16'h8D00, 16, 0, rx);
      check("t2_int1_ctrl", rx, 8'h02);
      spi_frame(16'h9100, 16, 0, rx);
      check("t2_ctrl2_g", rx, 8'h50);
      wait_int("t2_int_timeout", x1);
      lat = x1 - cfg_cyc;
      check("t2_int_latency_in_window", (lat >= N - 2 && lat <= N + 2), 1'b1);

      // 3: snapshot reads, INT clear
      check("t3_int_set", INT, 1'b1);
      spi_frame(16'hA200, 16, 0, rx);
      check("t3_ptch_lo", rx, 8'h34);
      check("t3_int_cleared", INT, 1'b0);
      spi_frame(16'hA300, 16, 0, rx);
      check("t3_ptch_hi", rx, 8'h12);
      spi_frame(16'hAC00, 16, 0, rx);
      check("t3_az_lo", rx, 8'hDC);
      spi_frame(16'hAD00, 16, 0, rx);
      check("t3_az_hi", rx, 8'hFE);
      check("t3_no_ovr", ovr, 1'b0);

      // 6a: tick lands on the clearing cycle of a 0x22 read
      wait_int("t6_int_timeout", x2);
      check("t6_tick_period", x2 - x1, N);
      spi_frame(16'hA200, 16, x2 + N - 3, rx);
      check("t6_clr_tick_ptch", rx, 8'h34);
      check("t6_clr_tick_int", INT, 1'b1);
      check("t6_clr_tick_no_ovr", ovr, 1'b0);

      // 6b: two unread samples -> overrun, newest sample kept
      ptch_rt_smpl = 16'h5678;
      AZ_smpl      = 16'h9ABC;
      while (cyc < x2 + 2 * N + 5) step(1);
      check("t6_ovr_set", ovr, 1'b1);
      ptch_rt_smpl = 16'h0BAD;
      AZ_smpl      = 16'hCAFE;
      while (cyc < x2 + 3 * N + 5) step(1);
      spi_frame(16'hA200, 16, 0, rx);
      check("t6_ptch_lo_2nd", rx, 8'hAD);
      spi_frame(16'hA300, 16, 0, rx);
      check("t6_ptch_hi_2nd", rx, 8'h0B);
      spi_frame(16'hAC00, 16, 0, rx);
      check("t6_az_lo_2nd", rx, 8'hFE);
      spi_frame(16'hAD00, 16, 0, rx);
      check("t6_az_hi_2nd", rx, 8'hCA);
      check("t6_ovr_sticky", ovr, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
